// File: rtl/pointer_move_ctrl_pkg.sv
// pointer_move_ctrl_pkg: shared axis state, direction encoding and saturating step
package pointer_move_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} axis_state_t;

    typedef logic [1:0] dir_t;
    localparam dir_t DIR_NONE = 2'b00;
    localparam dir_t DIR_POS  = 2'b01;
    localparam dir_t DIR_NEG  = 2'b10;

    function automatic int sat_step(dir_t dir, int duty, int step, int lo, int hi);
        return (dir == DIR_POS) ? ((duty > hi - step) ? hi : duty + step) :
               (dir == DIR_NEG) ? ((duty < lo + step) ? lo : duty - step) : duty;
    endfunction

endpackage

// File: rtl/pointer_move_ctrl_if.sv
// pointer_move_ctrl_if: raw buttons in, duty words and status flags out
interface pointer_move_ctrl_if #(parameter int DUTY_W = 6);
    logic              Bt_Up, Bt_Down, Bt_Left, Bt_Right;
    logic [DUTY_W-1:0] Duty_X, Duty_Y;
    logic              Upd_X, Upd_Y, Sat_X, Sat_Y;

    modport master (output Bt_Up, Bt_Down, Bt_Left, Bt_Right,
                    input  Duty_X, Duty_Y, Upd_X, Upd_Y, Sat_X, Sat_Y);
    modport slave  (input  Bt_Up, Bt_Down, Bt_Left, Bt_Right,
                    output Duty_X, Duty_Y, Upd_X, Upd_Y, Sat_X, Sat_Y);
endinterface

// File: rtl/axis_stepper.sv
// axis_stepper: per-axis direction decode, step/auto-repeat FSM and saturating duty register
module axis_stepper
    import pointer_move_ctrl_pkg::*;
#(
    parameter int DUTY_W     = 6,
    parameter int STEP       = 4,
    parameter int DUTY_MIN   = 0,
    parameter int DUTY_MAX   = 60,
    parameter int DUTY_HOME  = 0,
    parameter int REPEAT_DLY = 25000000,
    parameter int REPEAT_CYC = 5000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              plus,
    input  logic              minus,
    output logic [DUTY_W-1:0] duty,
    output logic              upd,
    output logic              sat
);
    localparam int TMR_W = $clog2((REPEAT_DLY > REPEAT_CYC ? REPEAT_DLY : REPEAT_CYC) + 1);
    localparam logic [TMR_W-1:0]  DLY_LD = TMR_W'(REPEAT_DLY - 1);
    localparam logic [TMR_W-1:0]  CYC_LD = TMR_W'(REPEAT_CYC - 1);
    localparam logic [DUTY_W-1:0] HOME   = DUTY_W'(DUTY_HOME);
    localparam logic [DUTY_W-1:0] LO     = DUTY_W'(DUTY_MIN);
    localparam logic [DUTY_W-1:0] HI     = DUTY_W'(DUTY_MAX);

    axis_state_t       state_q, state_d;
    dir_t              dir, dir_q, dir_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic              upd_q, upd_d, sat_q, sat_d, step;

    assign dir = (plus & ~minus) ? DIR_POS : (minus & ~plus) ? DIR_NEG : DIR_NONE;

    // DELAY and REPEAT differ only in which reload brought them there, so they share one arm
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        step    = 1'b0;
        case (state_q)
            IDLE: if (dir != DIR_NONE) begin
                step    = 1'b1;
                timer_d = DLY_LD;
                state_d = DELAY;
            end
            default: if (dir == DIR_NONE) begin
                state_d = IDLE;
            end else if (dir != dir_q) begin
                step    = 1'b1;
                timer_d = DLY_LD;
                state_d = DELAY;
            end else if (timer_q == '0) begin
                step    = 1'b1;
                timer_d = CYC_LD;
                state_d = REPEAT;
            end else begin
                timer_d = timer_q - 1'b1;
            end
        endcase
        dir_d  = step ? dir : dir_q;
        duty_d = step ? DUTY_W'(sat_step(dir, int'(duty_q), STEP, DUTY_MIN, DUTY_MAX)) : duty_q;
        upd_d  = duty_d != duty_q;
        sat_d  = (duty_d == LO) || (duty_d == HI);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            dir_q   <= DIR_NONE;
            timer_q <= '0;
            duty_q  <= HOME;
            upd_q   <= 1'b0;
            sat_q   <= (HOME == LO) || (HOME == HI);
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            timer_q <= timer_d;
            duty_q  <= duty_d;
            upd_q   <= upd_d;
            sat_q   <= sat_d;
        end
    end

    assign duty = duty_q;
    assign upd  = upd_q;
    assign sat  = sat_q;
endmodule

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchroniser plus stability counter for one raw button
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d, done;

    assign done = (sync_q[1] != level_q) && (cnt_q == CNT_W'(DEBOUNCE_CYC - 1));

    always_comb begin
        sync_d  = {sync_q[0], btn};
        level_d = done ? sync_q[1] : level_q;
        cnt_d   = (sync_q[1] == level_q || done) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;
endmodule

// File: rtl/pointer_move_ctrl.sv
// pointer_move_ctrl: four debounced buttons driving independent X/Y saturating duty steppers
module pointer_move_ctrl #(
    parameter int DUTY_W       = 6,
    parameter int STEP         = 4,
    parameter int DUTY_MIN     = 0,
    parameter int DUTY_MAX     = 60,
    parameter int DUTY_HOME    = 0,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int REPEAT_DLY   = 25000000,
    parameter int REPEAT_CYC   = 5000000
) (
    input logic                clk,
    input logic                reset,
    pointer_move_ctrl_if.slave bus
);
    logic [3:0] raw, lvl;

    assign raw = {bus.Bt_Right, bus.Bt_Left, bus.Bt_Down, bus.Bt_Up};

    for (genvar i = 0; i < 4; i++) begin : g_db
        btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
            .clk(clk), .reset(reset), .btn(raw[i]), .level(lvl[i])
        );
    end

    axis_stepper #(
        .DUTY_W(DUTY_W), .STEP(STEP), .DUTY_MIN(DUTY_MIN), .DUTY_MAX(DUTY_MAX),
        .DUTY_HOME(DUTY_HOME), .REPEAT_DLY(REPEAT_DLY), .REPEAT_CYC(REPEAT_CYC)
    ) u_x (
        .clk(clk), .reset(reset), .plus(lvl[3]), .minus(lvl[2]),
        .duty(bus.Duty_X), .upd(bus.Upd_X), .sat(bus.Sat_X)
    );

    axis_stepper #(
        .DUTY_W(DUTY_W), .STEP(STEP), .DUTY_MIN(DUTY_MIN), .DUTY_MAX(DUTY_MAX),
        .DUTY_HOME(DUTY_HOME), .REPEAT_DLY(REPEAT_DLY), .REPEAT_CYC(REPEAT_CYC)
    ) u_y (
        .clk(clk), .reset(reset), .plus(lvl[0]), .minus(lvl[1]),
        .duty(bus.Duty_Y), .upd(bus.Upd_Y), .sat(bus.Sat_Y)
    );
endmodule

// File: tb/tb_pointer_move_ctrl.sv
// tb_pointer_move_ctrl: directed scenarios with hand-computed duty values and pulse timing
module tb_pointer_move_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    pointer_move_ctrl_if #(.DUTY_W(6)) bus();

    pointer_move_ctrl #(
        .DUTY_W(6), .STEP(4), .DUTY_MIN(0), .DUTY_MAX(60), .DUTY_HOME(0),
        .DEBOUNCE_CYC(4), .REPEAT_DLY(20), .REPEAT_CYC(8)
    ) dut (.clk(clk), .reset(reset), .bus(bus));

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        bus.Bt_Up = 0; bus.Bt_Down = 0; bus.Bt_Left = 0; bus.Bt_Right = 0;
        #23 reset = 1'b1;
        #1;
        n_checks++; if (bus.Duty_X !== 6'd0) begin n_fail++; $display("FAIL reset_duty_x: got %0d want 0", bus.Duty_X); end
        n_checks++; if (bus.Duty_Y !== 6'd0) begin n_fail++; $display("FAIL reset_duty_y: got %0d want 0", bus.Duty_Y); end
        n_checks++; if (bus.Sat_X !== 1'b1) begin n_fail++; $display("FAIL reset_sat_x: got %b want 1", bus.Sat_X); end
        n_checks++; if (bus.Sat_Y !== 1'b1) begin n_fail++; $display("FAIL reset_sat_y: got %b want 1", bus.Sat_Y); end
        n_checks++; if (bus.Upd_X !== 1'b0) begin n_fail++; $display("FAIL reset_upd_x: got %b want 0", bus.Upd_X); end
        n_checks++; if (bus.Upd_Y !== 1'b0) begin n_fail++; $display("FAIL reset_upd_y: got %b want 0", bus.Upd_Y); end
        cyc(2);
        reset = 1'b0;
    endtask

    task automatic test_bounce;
        int pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) bus.Bt_Right = ~bus.Bt_Right;
            @(negedge clk);
            if (bus.Upd_X) pulses++;
        end
        bus.Bt_Right = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.Upd_X) pulses++;
        end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL bounce_upd_x: got %0d pulses want 0", pulses); end
        n_checks++; if (bus.Duty_X !== 6'd0) begin n_fail++; $display("FAIL bounce_duty_x: got %0d want 0", bus.Duty_X); end
    endtask

    task automatic test_single_press;
        int pulses = 0;
        bus.Bt_Up = 1;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            if (bus.Upd_Y) pulses++;
            if (k == 6) begin
                n_checks++; if (bus.Duty_Y !== 6'd0) begin n_fail++; $display("FAIL press_early_y: got %0d want 0", bus.Duty_Y); end
            end
            if (k == 7) begin
                n_checks++; if (bus.Duty_Y !== 6'd4) begin n_fail++; $display("FAIL press_step_y: got %0d want 4", bus.Duty_Y); end
                n_checks++; if (bus.Upd_Y !== 1'b1) begin n_fail++; $display("FAIL press_upd_y: got %b want 1", bus.Upd_Y); end
            end
            if (k == 8) begin
                n_checks++; if (bus.Upd_Y !== 1'b0) begin n_fail++; $display("FAIL press_upd_width: got %b want 0", bus.Upd_Y); end
            end
            if (k == 10) bus.Bt_Up = 0;
        end
        n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL press_pulses: got %0d want 1", pulses); end
        n_checks++; if (bus.Duty_Y !== 6'd4) begin n_fail++; $display("FAIL press_final_y: got %0d want 4", bus.Duty_Y); end
        n_checks++; if (bus.Sat_Y !== 1'b0) begin n_fail++; $display("FAIL press_sat_y: got %b want 0", bus.Sat_Y); end
    endtask

    task automatic test_auto_repeat;
        int exp_k[7] = '{7, 27, 35, 43, 51, 59, 67};
        int idx = 0;
        bus.Bt_Right = 1;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (bus.Upd_X) begin
                if (idx < 7) begin
                    n_checks++; if (k !== exp_k[idx]) begin n_fail++; $display("FAIL repeat_time[%0d]: got cycle %0d want %0d", idx, k, exp_k[idx]); end
                    n_checks++; if (bus.Duty_X !== 6'(4 * (idx + 1))) begin n_fail++; $display("FAIL repeat_val[%0d]: got %0d want %0d", idx, bus.Duty_X, 4 * (idx + 1)); end
                end
                idx++;
            end
            if (k == 68) bus.Bt_Right = 0;
        end
        n_checks++; if (idx !== 7) begin n_fail++; $display("FAIL repeat_pulses: got %0d want 7", idx); end
        n_checks++; if (bus.Duty_X !== 6'd28) begin n_fail++; $display("FAIL repeat_final_x: got %0d want 28", bus.Duty_X); end
    endtask

    task automatic test_saturation;
        int pulses = 0;
        bus.Bt_Up = 1;
        for (int k = 1; k <= 160; k++) begin
            @(negedge clk);
            if (bus.Upd_Y) pulses++;
            if (k == 122) begin
                n_checks++; if (bus.Duty_Y !== 6'd56) begin n_fail++; $display("FAIL sat_pre_y: got %0d want 56", bus.Duty_Y); end
                n_checks++; if (bus.Sat_Y !== 1'b0) begin n_fail++; $display("FAIL sat_pre_flag: got %b want 0", bus.Sat_Y); end
            end
            if (k == 123) begin
                n_checks++; if (bus.Duty_Y !== 6'd60) begin n_fail++; $display("FAIL sat_hit_y: got %0d want 60", bus.Duty_Y); end
                n_checks++; if (bus.Sat_Y !== 1'b1) begin n_fail++; $display("FAIL sat_hit_flag: got %b want 1", bus.Sat_Y); end
            end
            if (k == 150) bus.Bt_Up = 0;
        end
        n_checks++; if (pulses !== 14) begin n_fail++; $display("FAIL sat_pulses: got %0d want 14", pulses); end
        n_checks++; if (bus.Duty_Y !== 6'd60) begin n_fail++; $display("FAIL sat_final_y: got %0d want 60", bus.Duty_Y); end
        n_checks++; if (bus.Duty_X !== 6'd28) begin n_fail++; $display("FAIL sat_x_idle: got %0d want 28", bus.Duty_X); end
    endtask

    task automatic test_low_bound;
        int pulses = 0;
        @(negedge clk); #2 reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        bus.Bt_Down = 1; bus.Bt_Left = 1;
        for (int k = 1; k <= 52; k++) begin
            @(negedge clk);
            if (bus.Upd_X || bus.Upd_Y) pulses++;
            if (k == 40) begin bus.Bt_Down = 0; bus.Bt_Left = 0; end
        end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL low_pulses: got %0d want 0", pulses); end
        n_checks++; if (bus.Duty_Y !== 6'd0) begin n_fail++; $display("FAIL low_duty_y: got %0d want 0", bus.Duty_Y); end
        n_checks++; if (bus.Duty_X !== 6'd0) begin n_fail++; $display("FAIL low_duty_x: got %0d want 0", bus.Duty_X); end
        n_checks++; if (bus.Sat_X !== 1'b1) begin n_fail++; $display("FAIL low_sat_x: got %b want 1", bus.Sat_X); end
    endtask

    task automatic test_opposing;
        int pulses = 0;
        bus.Bt_Right = 1; cyc(10); bus.Bt_Right = 0; cyc(12);
        n_checks++; if (bus.Duty_X !== 6'd4) begin n_fail++; $display("FAIL opp_setup_x: got %0d want 4", bus.Duty_X); end
        bus.Bt_Left = 1; bus.Bt_Right = 1;
        for (int k = 1; k <= 52; k++) begin
            @(negedge clk);
            if (bus.Upd_X) pulses++;
            if (k == 40) begin bus.Bt_Left = 0; bus.Bt_Right = 0; end
        end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL opp_pulses: got %0d want 0", pulses); end
        n_checks++; if (bus.Duty_X !== 6'd4) begin n_fail++; $display("FAIL opp_duty_x: got %0d want 4", bus.Duty_X); end
    endtask

    task automatic test_diagonal_reset;
        bus.Bt_Up = 1; bus.Bt_Right = 1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 7) begin
                n_checks++; if ({bus.Upd_X, bus.Upd_Y} !== 2'b11) begin n_fail++; $display("FAIL diag_upd: got %b%b want 11", bus.Upd_X, bus.Upd_Y); end
                n_checks++; if (bus.Duty_X !== 6'd8) begin n_fail++; $display("FAIL diag_x: got %0d want 8", bus.Duty_X); end
                n_checks++; if (bus.Duty_Y !== 6'd4) begin n_fail++; $display("FAIL diag_y: got %0d want 4", bus.Duty_Y); end
            end
            if (k == 35) begin
                n_checks++; if (bus.Duty_X !== 6'd16) begin n_fail++; $display("FAIL diag_rep_x: got %0d want 16", bus.Duty_X); end
                n_checks++; if (bus.Duty_Y !== 6'd12) begin n_fail++; $display("FAIL diag_rep_y: got %0d want 12", bus.Duty_Y); end
            end
        end
        bus.Bt_Up = 0;
        #2 reset = 1'b1;
        #1;
        n_checks++; if (bus.Duty_X !== 6'd0) begin n_fail++; $display("FAIL rst_rep_x: got %0d want 0", bus.Duty_X); end
        n_checks++; if (bus.Duty_Y !== 6'd0) begin n_fail++; $display("FAIL rst_rep_y: got %0d want 0", bus.Duty_Y); end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 6) begin
                n_checks++; if (bus.Duty_X !== 6'd0) begin n_fail++; $display("FAIL refresh_early_x: got %0d want 0", bus.Duty_X); end
            end
            if (k == 7) begin
                n_checks++; if (bus.Duty_X !== 6'd4) begin n_fail++; $display("FAIL refresh_x: got %0d want 4", bus.Duty_X); end
                n_checks++; if (bus.Upd_X !== 1'b1) begin n_fail++; $display("FAIL refresh_upd_x: got %b want 1", bus.Upd_X); end
                n_checks++; if (bus.Duty_Y !== 6'd0) begin n_fail++; $display("FAIL refresh_y: got %0d want 0", bus.Duty_Y); end
            end
        end
        bus.Bt_Right = 0;
        cyc(12);
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_single_press();
        test_auto_repeat();
        test_saturation();
        test_low_bound();
        test_opposing();
        test_diagonal_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
